// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_pkg
// Brief    : Shared types and width helpers for the register write arbiter.
// Revision : 1.0  initial release
// ============================================================================
package reg_write_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Hold counter must be able to hold the value MAX_HOLD itself.
    function automatic int cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_if
// Brief    : Requester-side bus plus shared-register drive of the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface reg_write_arbiter_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wr_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   reg_d;
    logic           reg_load;

    modport master (
        output req, lock, wr_data,
        input  gnt, ack, reg_d, reg_load
    );

    modport slave (
        input  req, lock, wr_data,
        output gnt, ack, reg_d, reg_load
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_rr_pick
// Brief    : Combinational cyclic first-set scan of req starting at ptr.
// Revision : 1.0  initial release
// ============================================================================
module reg_write_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            cand = sum[IW-1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin arbiter sharing one load register among N requesters.
// Revision : 1.0  initial release
// ============================================================================
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int MAX_HOLD = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    reg_write_arbiter_if.slave  bus
);

    localparam int IW = idx_width(N);
    localparam int HW = cnt_width(MAX_HOLD);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  gnt_q, gnt_d;

    logic [IW-1:0] rel_ptr;
    logic          idle_valid, rel_valid;
    logic [IW-1:0] idle_idx, rel_idx;
    logic          owner_req, owner_lock, burst_ok, write_en;
    logic [W-1:0]  owner_data;

    assign rel_ptr = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

    reg_write_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick_idle (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (idle_valid),
        .idx   (idle_idx)
    );

    reg_write_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick_rel (
        .req   (bus.req),
        .ptr   (rel_ptr),
        .valid (rel_valid),
        .idx   (rel_idx)
    );

    assign owner_req  = bus.req[owner_q];
    assign owner_lock = bus.lock[owner_q];
    assign owner_data = bus.wr_data[int'(owner_q)*W +: W];
    assign burst_ok   = (hold_q < HW'(MAX_HOLD));

    // Reset gates the write so a burst interrupted by rst never lands.
    assign write_en     = (state_q == ST_BUSY) && owner_req && !rst;
    assign bus.reg_load = write_en;
    assign bus.ack      = write_en ? gnt_q : '0;
    assign bus.reg_d    = (gnt_q != '0) ? owner_data : '0;
    assign bus.gnt      = gnt_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_valid) begin
                    state_d = ST_BUSY;
                    owner_d = idle_idx;
                    hold_d  = HW'(1);
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << idle_idx;
                end
            end
            ST_BUSY: begin
                if (owner_req && owner_lock && burst_ok) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    // Hand over in the same cycle so back-to-back writes have no bubble.
                    ptr_d = rel_ptr;
                    if (rel_valid) begin
                        owner_d = rel_idx;
                        hold_d  = HW'(1);
                        gnt_d   = {{(N-1){1'b0}}, 1'b1} << rel_idx;
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Scoreboard bench for reg_write_arbiter with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int N        = 4;
    localparam int W        = 16;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.N(N), .W(W)) bus ();

    reg_write_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The shared D/load/Q register the arbiter drives.
    logic [W-1:0] q_reg = '0;
    always @(posedge clk) if (bus.reg_load) q_reg <= bus.reg_d;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } wr_t;

    wr_t          exp_q[$];
    int           ack_log[$];
    logic [W-1:0] data_log[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N-1:0] ack_seen = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int scan(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Reference model: who holds the grant, where priority starts, writes in this grant.
    int           m_busy = 0;
    int           m_owner = 0;
    int           m_ptr = 0;
    int           m_cnt = 0;
    logic [W-1:0] m_q = '0;
    logic [N-1:0] exp_gnt = '0;
    logic [W-1:0] exp_q_val = '0;

    always @(negedge clk) begin : model
        int  w;
        bit  wrote;
        wr_t e;
        exp_gnt   = (m_busy != 0) ? (N'(1) << m_owner) : '0;
        exp_q_val = m_q;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_busy == 0) begin
            w = scan(bus.req, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_cnt = 1;
            end
        end else begin
            wrote = bus.req[m_owner];
            if (wrote) begin
                e.idx  = m_owner;
                e.data = bus.wr_data[m_owner*W +: W];
                exp_q.push_back(e);
                m_q = e.data;
            end
            if (wrote && bus.lock[m_owner] && m_cnt < MAX_HOLD) begin
                m_cnt++;
            end else begin
                m_ptr = (m_owner + 1) % N;
                w = scan(bus.req, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_cnt = 1;
                end else begin
                    m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        int  ai;
        #1;
        check("gnt", bus.gnt, exp_gnt);
        check("q_reg", q_reg, exp_q_val);
        if (rst) begin
            check("load_in_reset", bus.reg_load, 0);
            check("ack_in_reset", bus.ack, 0);
        end
        if (exp_gnt == '0) check("reg_d_idle", bus.reg_d, 0);
        ack_seen = bus.ack;
        if (bus.reg_load || bus.ack != '0) begin
            ai = -1;
            for (int i = 0; i < N; i++) if (bus.ack[i]) ai = i;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got ack %b load %b expected no write at %0t",
                         bus.ack, bus.reg_load, $time);
            end else begin
                e = exp_q.pop_front();
                check("ack", bus.ack, N'(1) << e.idx);
                check("reg_load", bus.reg_load, 1);
                check("reg_d", bus.reg_d, e.data);
            end
            ack_log.push_back(ai);
            data_log.push_back(bus.reg_d);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missed_write: got no write expected requester %0d at %0t",
                     exp_q[0].idx, $time);
            exp_q.delete();
        end
    end

    task automatic set_data(input int i, input logic [W-1:0] d);
        bus.wr_data[i*W +: W] = d;
    endtask

    initial begin : driver
        int rr_exp[5];
        int burst_exp[6];
        rr_exp    = '{0, 1, 2, 3, 0};
        burst_exp = '{0, 0, 0, 0, 1, 0};

        // All requesting through reset; priority must start at 0 afterwards.
        rst      = 1'b1;
        bus.req  = '1;
        bus.lock = '0;
        for (int i = 0; i < N; i++) set_data(i, W'(16'h0010 + i));
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #2;
        check("first_gnt_idle", bus.gnt, 0);
        @(negedge clk); #2;
        check("first_gnt", bus.gnt, 4'b0001);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k < ack_log.size()) begin
                check("rr_order", ack_log[k], rr_exp[k]);
                check("rr_data", data_log[k], 16'h0010 + rr_exp[k]);
            end else begin
                check("rr_count", ack_log.size(), 5);
            end
        end

        // Locked requester 0 against plain requester 1, entered through a reset.
        @(posedge clk); #2;
        rst      = 1'b1;
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        @(posedge clk); #2;
        rst = 1'b0;
        ack_log.delete();
        data_log.delete();
        repeat (14) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k < ack_log.size()) check("burst_order", ack_log[k], burst_exp[k]);
            else check("burst_count", ack_log.size(), 6);
        end

        // Requester 3 bursting, interrupted by reset.
        @(posedge clk); #2;
        bus.req  = 4'b1000;
        bus.lock = 4'b1000;
        set_data(3, 16'hBEEF);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        set_data(3, 16'h1234);
        @(posedge clk); #2;
        rst     = 1'b0;
        bus.req = '0;
        bus.lock = '0;
        @(negedge clk); #2;
        check("gnt_after_reset", bus.gnt, 0);
        check("q_hold_after_reset", q_reg, 16'hBEEF);

        // Randomised requesters with bursts, withdrawals and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            rst = ($urandom % 256 == 0);
            for (int i = 0; i < N; i++) begin
                if (ack_seen[i] && bus.lock[i] && ($urandom % 4 != 0)) begin
                    set_data(i, W'($urandom));
                end else if (ack_seen[i] || !bus.req[i]) begin
                    if ($urandom % 3 == 0) begin
                        bus.req[i]  = 1'b1;
                        bus.lock[i] = 1'($urandom % 2);
                        set_data(i, W'($urandom));
                    end else begin
                        bus.req[i]  = 1'b0;
                        bus.lock[i] = 1'b0;
                    end
                end else if ($urandom % 40 == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
        end
        @(posedge clk); #2;
        rst      = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        repeat (4) @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Round-robin arbiter that shares one 16-bit load register (D/load/Q style, synchronous load) among N requesters. It grants exactly one requester at a time and drives the register's data and load inputs from that requester. It returns a per-requester write acknowledge. An optional lock lets a requester perform a bounded burst of back-to-back writes. It sits between requester blocks and the shared register instance.

Parameters:
N, 4, number of requesters (2..8)
W, 16, data width, matches the shared register
MAX_HOLD, 4, maximum consecutive writes per grant when lock is held (>=1; 1 disables bursting)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  per-requester write request; held until ack
lock  input  N  per-requester burst request, sampled with req
wr_data  input  N*W  requester i data in bits [i*W +: W]
gnt  output  N  registered one-hot grant, all-zero when idle
ack  output  N  one-cycle pulse per completed write; one-hot or zero
reg_d  output  W  data to shared register D input
reg_load  output  1  load enable to shared register

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, ptr=0, owner=0, hold_cnt=0. While rst is high, reg_load=0 and ack=0, regardless of state, including reset mid-burst. reg_d=0 when gnt=0.
- State registers: state {IDLE, BUSY}, owner index, ptr (next-priority index, 0..N-1), hold_cnt (width clog2(MAX_HOLD+1)).
- Winner selection (combinational):
  - Winner = first i with req[i]=1, scanning cyclically from ptr.
  - No req means no winner.
- IDLE:
  - gnt=0, reg_load=0.
  - If a winner exists: next state BUSY, owner=winner, gnt=onehot(winner), hold_cnt=1.
  - Latency: req rising in IDLE at cycle t gives gnt at t+1 and the write at the t+1 edge into t+2.
- BUSY:
  - reg_d = wr_data[owner].
  - reg_load = req[owner].
  - ack[owner] = reg_load. The shared register captures reg_d on the same edge ack is high.
- BUSY transitions at each edge:
  - Stay: req[owner] & lock[owner] & (hold_cnt < MAX_HOLD). Owner unchanged, hold_cnt+1, another write next cycle.
  - Otherwise release: ptr = (owner+1) mod N. Rerun the winner scan using the new ptr, within the same cycle.
    - Winner found: stay BUSY, owner=new winner, gnt updated, hold_cnt=1. No idle bubble.
    - No winner: go to IDLE, gnt=0.
- Owner drops req while granted: no write (reg_load=0, ack=0), released at that edge.
- Fairness:
  - A non-locked requester gets exactly one write per grant.
  - A locked requester gets at most MAX_HOLD writes, then is forced to release.
  - Worst-case wait for any requester: (N-1)*MAX_HOLD writes.
- Requester contract: keep req, lock and wr_data stable from assertion until the cycle ack is seen. Deassert or present new data the cycle after ack.
- Simultaneous requests from all N in IDLE after reset: grant order 0,1,...,N-1,0...
- ptr advances only on release from BUSY, never in IDLE.

Decomposition:
- Shared include reg_arb_defs.vh: state encodings ST_IDLE/ST_BUSY; a localparam helper for the clog2 width of hold_cnt and of the index.
- One natural sub-module: rr_pick (combinational). Inputs: req[N], ptr. Outputs: valid, idx.
- Instantiate rr_pick twice: once with ptr for IDLE, once with (owner+1) mod N for release. Alternatively, use one instance with a muxed ptr.

Test Plan:
- Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0, reg_load=0, ack=0 throughout; first gnt=4'b0001 one cycle after rst falls.
- Single request: req=4'b0100, wr_data[2]=16'h0005, lock=0 -> gnt=4'b0100 next cycle; reg_load=1, reg_d=16'h0005, ack[2]=1 for exactly one cycle; register Q=16'h0005 after that edge; then IDLE.
- Round-robin: req=4'b1111 held, lock=0, data_i=16'h0010+i -> ack order 0,1,2,3,0 on consecutive cycles with no bubble; Q sequence 16'h10,11,12,13,10.
- Burst limit: MAX_HOLD=4, req=4'b0011, lock[0]=1 -> requester 0 acked 4 consecutive cycles, then requester 1 acked once, then requester 0 again.
- Owner withdrawal: grant requester 1, then drop req[1] before the edge -> reg_load=0, no ack, Q unchanged; grant passes to next requester or IDLE.
- Reset mid-burst: rst=1 during a requester 3 locked burst -> reg_load/ack forced 0 that cycle; next cycle gnt=0, ptr=0; Q holds its last written value.
